// File: rtl/restoring_division_pkg.sv
// rtl/restoring_division_pkg.sv - shared types and constants for the restoring divider
package restoring_division_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_division_step.sv
// rtl/restoring_division_step.sv - one combinational restoring-division iteration
module restoring_division_step
    import restoring_division_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_shift;
    logic [WIDTH:0] diff;
    logic           a_msb_unused;

    // The top bit of A shifts out of the {A,Q} pair; it is never set for a valid run.
    assign a_msb_unused = a[WIDTH];
    assign a_shift      = {a[WIDTH-1:0], q[WIDTH-1]};
    assign diff         = a_shift - {1'b0, m};

    always_comb begin
        a_next = diff;
        q_next = {q[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            a_next    = a_shift;
            q_next[0] = 1'b0;
        end
    end

endmodule

// File: rtl/restoring_division.sv
// rtl/restoring_division.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_division
    import restoring_division_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dest_valid,
    input  logic             dest_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH == DEFAULT_WIDTH) ? CNT_W : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;

    restoring_division_step #(.WIDTH(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .m      (m),
        .a_next (a_next),
        .q_next (q_next)
    );

    assign src_ready  = (state == IDLE) && !rst;
    assign dest_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src_valid) begin
                        a     <= '0;
                        q     <= dividend;
                        m     <= divisor;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a     <= a_next;
                    q     <= q_next;
                    count <= count + CW'(1);
                    // Results are taken straight from the step outputs of the final iteration.
                    if (count == LAST_ITER) begin
                        quotient  <= q_next;
                        remainder <= a_next[WIDTH-1:0];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (dest_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_division.sv
// tb/tb_restoring_division.sv - self-checking bench for restoring_division
module tb_restoring_division;

    localparam int W = 16;
    localparam int LATENCY = W + 1;
    localparam int N_RANDOM = 1000;

    logic         clk;
    logic         rst;
    logic         src_valid;
    logic         src_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         dest_valid;
    logic         dest_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0]  exp_q[$];
    int           acc_cyc = 0;
    int           acc_cnt = 0;
    int           done_cnt = 0;
    logic         busy = 0;
    logic         prev_dv = 0;
    logic         prev_dr = 0;
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    restoring_division dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .dest_valid (dest_valid),
        .dest_ready (dest_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, divide-by-zero gives all ones and the dividend.
    function automatic logic [31:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        if (b == 0) begin
            mq = '1;
            mr = a;
        end else begin
            mq = a / b;
            mr = a % b;
        end
        return {mq, mr};
    endfunction

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            busy    = 0;
            prev_dv = 0;
            prev_dr = 0;
        end else begin
            if (busy) check("src_ready_while_busy", {31'd0, src_ready}, 32'd0);
            if (dest_valid) begin
                check("dest_valid_has_pending_op", {31'd0, busy}, 32'd1);
                if (!prev_dv) begin
                    check("latency", cyc - acc_cyc, LATENCY);
                end else if (!prev_dr) begin
                    check("hold_quotient", {16'd0, quotient}, {16'd0, prev_q});
                    check("hold_remainder", {16'd0, remainder}, {16'd0, prev_r});
                end
                if (dest_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("quotient", {16'd0, quotient}, {16'd0, e[31:16]});
                    check("remainder", {16'd0, remainder}, {16'd0, e[15:0]});
                    last_q = quotient;
                    last_r = remainder;
                    done_cnt++;
                    busy = 0;
                end
            end
            if (src_valid && src_ready) begin
                exp_q.push_back(model(dividend, divisor));
                acc_cyc = cyc;
                acc_cnt++;
                busy = 1;
            end
            prev_dv = dest_valid;
            prev_dr = dest_ready;
            prev_q  = quotient;
            prev_r  = remainder;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        logic hs;
        int   n;
        hs = 0;
        n  = 0;
        @(posedge clk);
        #1;
        src_valid = 1;
        dividend  = a;
        divisor   = b;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = src_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (!hs) check("send_timeout", 32'd0, 32'd1);
        src_valid = 0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
    endtask

    task automatic receive(input int stall);
        int n;
        n = 0;
        if (stall == 0) dest_ready = 1;
        while (!dest_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!dest_valid) check("receive_timeout", 32'd0, 32'd1);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        dest_ready = 1;
        @(posedge clk);
        #1;
        dest_ready = 0;
        check("dest_valid_drops", {31'd0, dest_valid}, 32'd0);
        check("src_ready_returns", {31'd0, src_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        send(a, b);
        receive(stall);
        check({tag, "_q"}, {16'd0, last_q}, {16'd0, eq});
        check({tag, "_r"}, {16'd0, last_r}, {16'd0, er});
    endtask

    initial begin
        rst        = 1;
        src_valid  = 0;
        dividend   = '0;
        divisor    = '0;
        dest_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_src_ready", {31'd0, src_ready}, 32'd0);
        check("reset_dest_valid", {31'd0, dest_valid}, 32'd0);
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        check("reset_remainder", {16'd0, remainder}, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("release_src_ready", {31'd0, src_ready}, 32'd1);

        run_op(16'd100, 16'd7, 0, 16'd14, 16'd2, "t1_100_7");
        run_op(16'hFFFF, 16'd1, 0, 16'hFFFF, 16'd0, "t2_max_1");
        run_op(16'd5, 16'd10, 0, 16'd0, 16'd5, "t2_small");
        run_op(16'd1234, 16'd0, 0, 16'hFFFF, 16'd1234, "t3_div0");
        run_op(16'd50000, 16'd255, 10, 16'd196, 16'd20, "t4_backpressure");

        send(16'd1000, 16'd3);
        repeat (8) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        check("midop_rst_src_ready", {31'd0, src_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("midop_src_ready", {31'd0, src_ready}, 32'd1);
        check("midop_quotient", {16'd0, quotient}, 32'd0);
        check("midop_remainder", {16'd0, remainder}, 32'd0);
        repeat (20) begin
            @(negedge clk);
            check("midop_no_dest_valid", {31'd0, dest_valid}, 32'd0);
        end
        run_op(16'd1000, 16'd3, 0, 16'd333, 16'd1, "t5_after_rst");

        acc_cnt  = 0;
        done_cnt = 0;
        fork
            begin
                for (int i = 0; i < N_RANDOM; i++) begin
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    int mode;
                    mode = $urandom_range(0, 7);
                    a = W'($urandom);
                    if (mode == 0) b = '0;
                    else if (mode < 3) b = W'($urandom_range(1, 15));
                    else if (mode == 3) b = a + W'($urandom_range(0, 3));
                    else b = W'($urandom);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    send(a, b);
                end
            end
            begin
                int n;
                n = 0;
                while (done_cnt < N_RANDOM && n < 60000) begin
                    @(posedge clk);
                    #1;
                    dest_ready = ($urandom_range(0, 2) != 0);
                    n++;
                end
                dest_ready = 0;
            end
        join
        repeat (3) @(posedge clk);
        check("random_accepted", acc_cnt, N_RANDOM);
        check("random_completed", done_cnt, N_RANDOM);
        check("random_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
